// File: rtl/sram_req_ctrl.sv
// rtl/sram_req_ctrl.sv - host request controller owning the single-port SRAM port
// Define SRAM_REQ_CTRL_INIT_EN to zero-fill the memory after every reset.
module sram_req_ctrl #(
  parameter int AW       = 3,
  parameter int DW       = 32,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic [AW-1:0] resp_addr,
  output logic [AW-1:0] mem_add,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_RESP
`ifdef SRAM_REQ_CTRL_INIT_EN
    , S_INIT
`endif
  } state_e;

`ifdef SRAM_REQ_CTRL_INIT_EN
  localparam state_e RESET_STATE = S_INIT;
`else
  localparam state_e RESET_STATE = S_IDLE;
`endif

  state_e state_q, state_d;

  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] mem_add_q, mem_add_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wd_q, mem_wd_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic [AW-1:0] resp_addr_q, resp_addr_d;
`ifdef SRAM_REQ_CTRL_INIT_EN
  logic [AW-1:0] init_q, init_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (req_valid && !req_we) state_d = S_RD_WAIT;
      S_RD_WAIT: if (cnt_q == 3'd0) state_d = S_RD_RESP;
      S_RD_RESP: if (resp_ready) state_d = S_IDLE;
`ifdef SRAM_REQ_CTRL_INIT_EN
      S_INIT:    if (init_q == '1) state_d = S_IDLE;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  // Everything on the SRAM side holds its value unless a state below overrides it;
  // mem_we alone defaults low so it is a one-cycle pulse.
  always_comb begin
    cnt_d        = cnt_q;
    mem_add_d    = mem_add_q;
    mem_we_d     = 1'b0;
    mem_wd_d     = mem_wd_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_addr_d  = resp_addr_q;
`ifdef SRAM_REQ_CTRL_INIT_EN
    init_d       = init_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mem_add_d = req_addr;
          if (req_we) begin
            mem_we_d = 1'b1;
            mem_wd_d = req_wdata;
          end else begin
            resp_addr_d = req_addr;
            cnt_d       = 3'(READ_LAT);
          end
        end
      end
      S_RD_WAIT: begin
        // Counter reaching zero means mem_rd now carries the addressed word.
        if (cnt_q == 3'd0) begin
          resp_rdata_d = mem_rd;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RD_RESP: begin
        if (resp_ready) resp_valid_d = 1'b0;
      end
`ifdef SRAM_REQ_CTRL_INIT_EN
      S_INIT: begin
        mem_we_d  = 1'b1;
        mem_wd_d  = '0;
        mem_add_d = init_q;
        init_d    = init_q + 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= 3'd0;
      mem_add_q    <= '0;
      mem_we_q     <= 1'b0;
      mem_wd_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_addr_q  <= '0;
`ifdef SRAM_REQ_CTRL_INIT_EN
      init_q       <= '0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      mem_add_q    <= mem_add_d;
      mem_we_q     <= mem_we_d;
      mem_wd_q     <= mem_wd_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_addr_q  <= resp_addr_d;
`ifdef SRAM_REQ_CTRL_INIT_EN
      init_q       <= init_d;
`endif
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_addr  = resp_addr_q;
  assign mem_add    = mem_add_q;
  assign mem_we     = mem_we_q;
  assign mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb/tb_sram_req_ctrl.sv - randomized self-checking bench for sram_req_ctrl with an SRAM model
module tb_sram_req_ctrl;
  localparam int AW       = 3;
  localparam int DW       = 32;
  localparam int READ_LAT = 1;
  localparam int DEPTH    = 1 << AW;
`ifdef SRAM_REQ_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] resp_addr;
  logic [AW-1:0] mem_add;
  logic          mem_we;
  logic [DW-1:0] mem_wd, mem_rd;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] ref_mem [DEPTH];

  sram_req_ctrl #(.AW(AW), .DW(DW), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_addr(resp_addr),
    .mem_add(mem_add), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // SRAM: write commits at the edge after mem_we, read data READ_LAT edges after the address.
  logic [DW-1:0] sram    [DEPTH];
  logic [DW-1:0] rd_pipe [READ_LAT];
  always @(posedge clk) begin
    if (mem_we) sram[mem_add] <= mem_wd;
    rd_pipe[0] <= sram[mem_add];
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rd = rd_pipe[READ_LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic after_reset();
`ifdef SRAM_REQ_CTRL_INIT_EN
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check("init_we", mem_we, 1);
      check("init_add", mem_add, i);
      check("init_wd", mem_wd, 0);
      check("init_ready", req_ready, (i == DEPTH-1) ? 1 : 0);
      ref_mem[i] = '0;
    end
`endif
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    check("wr_ready_pre", req_ready, 1);
    tick();
    check("wr_we", mem_we, 1);
    check("wr_add", mem_add, a);
    check("wr_wd", mem_wd, d);
    check("wr_ready_post", req_ready, 1);
    ref_mem[a] = d;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold, input bit noisy);
    logic [DW-1:0] exp;
    exp = ref_mem[a];
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = $urandom;
    check("rd_ready_pre", req_ready, 1);
    tick();
    check("rd_we", mem_we, 0);
    check("rd_add", mem_add, a);
    check("rd_ready_busy", req_ready, 0);
    check("rd_busy", busy, 1);
    req_valid = noisy; req_we = 1'($urandom); req_addr = a ^ 3'd5; req_wdata = $urandom;
    for (int k = 0; k < READ_LAT; k++) begin
      tick();
      check("rd_wait_valid", resp_valid, 0);
      check("rd_wait_we", mem_we, 0);
    end
    tick();
    check("rd_valid", resp_valid, 1);
    check("rd_data", resp_rdata, exp);
    check("rd_addr", resp_addr, a);
    for (int k = 0; k < hold; k++) begin
      tick();
      check("hold_valid", resp_valid, 1);
      check("hold_data", resp_rdata, exp);
      check("hold_addr", resp_addr, a);
      check("hold_ready", req_ready, 0);
      check("hold_add", mem_add, a);
      check("hold_we", mem_we, 0);
    end
    resp_ready = 1'b1;
    tick();
    check("rd_done_valid", resp_valid, 0);
    check("rd_done_ready", req_ready, 1);
    check("rd_done_busy", busy, 0);
    check("rd_done_we", mem_we, 0);
    resp_ready = 1'b0; req_valid = 1'b0; req_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) tick();
    check("rst_ready", req_ready, !INIT_EN);
    check("rst_busy", busy, INIT_EN);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_addr", resp_addr, 0);
    check("rst_mem_add", mem_add, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wd", mem_wd, 0);
    reset = 1'b0;
    after_reset();
    check("post_rst_ready", req_ready, 1);

`ifdef SRAM_REQ_CTRL_INIT_EN
    do_read(3'd6, 0, 1'b0);
`endif

    do_write(3'd3, 32'hDEADBEEF);
    tick();
    check("single_we_pulse", mem_we, 0);
    do_read(3'd3, 0, 1'b0);

    for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 32'h10000000 + i);
    tick();
    check("burst_we_end", mem_we, 0);
    for (int i = 0; i < DEPTH; i++) do_read(AW'(i), 0, 1'b0);

    do_read(3'd2, 5, 1'b1);

    do_write(3'd5, 32'hA5A5A5A5);
    do_read(3'd5, 0, 1'b0);

    // reset while a read is waiting on the SRAM
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd1;
    tick();
    req_valid = 1'b0;
    check("mid_rd_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", resp_valid, 0);
    check("mid_rst_ready", req_ready, !INIT_EN);
    check("mid_rst_we", mem_we, 0);
    after_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("no_stale_valid", resp_valid, 0);
    end

    // write presented on the reset edge must not reach the SRAM
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd4; req_wdata = 32'hBAD0BAD0;
    reset = 1'b1;
    tick();
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    check("rst_wr_we", mem_we, 0);
    after_reset();
    tick();
    check("rst_wr_we_after", mem_we, 0);
    do_read(3'd4, 0, 1'b0);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(AW'($urandom_range(0, DEPTH-1)), $urandom);
      else
        do_read(AW'($urandom_range(0, DEPTH-1)), $urandom_range(0, 3), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Initiator-side controller for the single-port flop-based SRAM (8x32 by default).
- Accepts read/write requests from a host over a valid/ready handshake.
- Drives the SRAM port (address, write enable, write data) from registers and captures the SRAM read data.
- Returns each read result over a valid/ready response channel. It is the block that owns all accesses to the memory instance.

Parameters:
AW, 3, address width; memory depth = 2**AW
DW, 32, data width
READ_LAT, 1, SRAM read latency in clock edges from address sampled to rd valid; legal 1..4

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  host request valid
req_ready  output  1  controller can accept a request
req_we  input  1  1=write, 0=read
req_addr  input  AW  request address
req_wdata  input  DW  write data (ignored on reads)
resp_valid  output  1  read response valid
resp_ready  input  1  host accepts response
resp_rdata  output  DW  read data
resp_addr  output  AW  address of the returned read
mem_add  output  AW  SRAM address (registered)
mem_we  output  1  SRAM write enable (registered)
mem_wd  output  DW  SRAM write data (registered)
mem_rd  input  DW  SRAM read data
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (sampled at posedge, reset=1): state=IDLE (INIT if the optional feature is enabled). Outputs are req_ready=1, resp_valid=0, resp_rdata=0, resp_addr=0, mem_add=0, mem_we=0, mem_wd=0, busy=0.
- Accept: at an edge with req_valid && req_ready. mem_* are updated at that same edge (E0).
- Write, accepted at E0:
  - mem_we=1, mem_add=req_addr, mem_wd=req_wdata for exactly one cycle (E0..E1); the SRAM writes at E1.
  - No response is produced. The state stays IDLE and req_ready stays 1, so back-to-back writes run at one per cycle.
- Read, accepted at E0:
  - mem_we=0, mem_add=req_addr. resp_addr latches req_addr. State goes to RD_WAIT with wait counter=READ_LAT.
  - The counter decrements each edge. At edge E0+READ_LAT+1, resp_rdata captures mem_rd, resp_valid is set to 1 and state goes to RD_RESP.
  - Latency with READ_LAT=1: resp_valid is high starting two edges after the accept edge.
- RD_RESP:
  - resp_valid, resp_rdata and resp_addr hold stable until an edge with resp_ready=1.
  - At that edge resp_valid goes to 0 and state goes to IDLE.
  - req_ready is 0 throughout RD_WAIT and RD_RESP. Only one read is outstanding at a time.
- req_ready = (state==IDLE), registered.
- mem_we is 0 in every cycle that does not follow an accepted write.
- Idle mem_add holds its last value; mem_wd holds its last value.
- Read-after-write to the same address in consecutive cycles returns the new data, because the write commits at E1 before the read address is sampled at E2. No forwarding logic is required.
- Request inputs are ignored whenever req_ready=0; there is no buffering.
- Reset mid-operation has priority over everything:
  - An in-flight read is dropped and resp_valid is forced to 0.
  - mem_we is forced to 0, so a write accepted at the same edge as reset is not issued.
- Addresses use the full AW width; no out-of-range case exists.

Optional Feature:
- Macro: SRAM_REQ_CTRL_INIT_EN.
- Defined:
  - After reset deasserts, state=INIT. An AW-bit counter walks addresses 0..2**AW-1, driving mem_we=1, mem_wd=0, one address per cycle.
  - req_ready=0 and busy=1 during INIT. The state goes to IDLE after the last address is issued.
  - Reset asserted during INIT restarts the walk at 0.
- Not defined: the INIT state and its counter are absent, and req_ready=1 from the first cycle after reset. The memory contents are undefined until written.

Test Plan:
1. Reset 3 cycles; write 0xDEADBEEF to addr 3, then read addr 3 -> mem_we high for one cycle; resp_valid high two edges after the read accept; resp_rdata=0xDEADBEEF, resp_addr=3.
2. Writes to addr 0..7 with data 0x10000000+i on 8 consecutive cycles, then read each -> req_ready stays 1 through the writes; mem_we high 8 cycles; each read returns 0x10000000+addr.
3. Read addr 2 with resp_ready held 0 for 5 cycles while req_valid=1 -> resp_valid/resp_rdata/resp_addr stable; req_ready=0; no new mem_add change until the handshake; IDLE on the following edge.
4. Write 0xA5A5A5A5 to addr 5, read addr 5 on the very next cycle -> resp_rdata=0xA5A5A5A5.
5. Assert reset for 1 cycle while in RD_WAIT -> resp_valid=0 and req_ready=1 after that edge; no stale response ever appears.
6. With SRAM_REQ_CTRL_INIT_EN: release reset -> mem_we=1 for 8 cycles, addr 0..7, wd=0, req_ready=0; a subsequent read of addr 6 returns 0x00000000.
